// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters, the arbiter and the 4:1 mux it steers.
// The master side drives requests; the slave side (arbiter) returns grant, select and busy.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic       busy;

  modport master (
    output req,
    input  gnt,
    input  s1,
    input  s0,
    input  busy
  );

  modport slave (
    input  req,
    output gnt,
    output s1,
    output s0,
    output busy
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter steering a mux4to1: four level requests, bounded hold time,
// registered one-hot grant plus binary select {s1,s0}.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no owner; gnt = 0, select holds the last owner's index
//   GRANT | requester own[1:0] owns the mux; hcnt counts its cycles
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mux4_rr_arbiter_if.slave  arb
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state, nxt_state;
  logic [1:0] own, nxt_own;
  logic [1:0] last;
  logic [3:0] hcnt, nxt_hcnt;
  logic [3:0] own_mask;
  logic [3:0] req_oth;
  logic [1:0] pick_any, pick_oth;
  logic       others;

  // First set bit in the order base+1, base+2, base+3, base (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    rr_pick = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    own_mask = 4'b0001 << own;
    req_oth  = arb.req & ~own_mask;
    others   = |req_oth;
    pick_any = rr_pick(arb.req, last);
    pick_oth = rr_pick(req_oth, last);
  end

  always_comb begin
    nxt_state = state;
    nxt_own   = own;
    nxt_hcnt  = hcnt;
    case (state)
      IDLE: begin
        if (|arb.req) begin
          nxt_state = GRANT;
          nxt_own   = pick_any;
          nxt_hcnt  = 4'd0;
        end
      end
      GRANT: begin
        if (arb.req[own]) begin
          if (hcnt < HOLD_LAST) begin
            nxt_hcnt = hcnt + 4'd1;
          end else if (others) begin
            nxt_own  = pick_oth;
            nxt_hcnt = 4'd0;
          end
        end else if (others) begin
          nxt_own  = pick_oth;
          nxt_hcnt = 4'd0;
        end else begin
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Outputs are loaded from the next-state values so they change on the same edge as the owner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      own      <= 2'd0;
      last     <= 2'd3;
      hcnt     <= 4'd0;
      arb.gnt  <= 4'b0000;
      arb.s1   <= 1'b0;
      arb.s0   <= 1'b0;
      arb.busy <= 1'b0;
    end else begin
      state <= nxt_state;
      own   <= nxt_own;
      hcnt  <= nxt_hcnt;
      if (nxt_state == GRANT) begin
        last     <= nxt_own;
        arb.gnt  <= 4'b0001 << nxt_own;
        arb.s1   <= nxt_own[1];
        arb.s0   <= nxt_own[0];
        arb.busy <= 1'b1;
      end else begin
        arb.gnt  <= 4'b0000;
        arb.busy <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, legal range 2..15: maximum consecutive grant cycles while another requester waits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req  input  4  level request per requester; bit i = mux input i (0=w, 1=x, 2=y, 3=z).
REQ-005 SHALL have port gnt  output  4  registered one-hot grant, or 0 when idle.
REQ-006 SHALL have port s1  output  1  registered mux select MSB, driving mux4to1 s1.
REQ-007 SHALL have port s0  output  1  registered mux select LSB, driving mux4to1 s0.
REQ-008 SHALL have port busy  output  1  registered; 1 iff gnt != 0.

Function
REQ-009 SHALL implement a two-state FSM: IDLE (no owner) and GRANT (owner index own[1:0] valid).
REQ-010 SHALL keep a round-robin pointer last[1:0] = index of most recent owner; search order = last+1, last+2, last+3, last (mod 4).
REQ-011 SHALL keep a hold counter hcnt (4 bits) counting owner grant cycles, saturating at MAX_HOLD-1.
REQ-012 IDLE, req == 0: remain IDLE; gnt = 0; s1/s0 hold their previous values.
REQ-013 IDLE, req != 0 at edge N: at edge N enter GRANT with owner = first set bit in search order; gnt/s1/s0/busy valid from cycle N+1 (1-cycle latency); hcnt = 0; last = owner.
REQ-014 GRANT, req[own] = 1, hcnt < MAX_HOLD-1: keep owner; hcnt increments.
REQ-015 GRANT, req[own] = 1, hcnt = MAX_HOLD-1, no other req bit set: keep owner; hcnt stays saturated.
REQ-016 GRANT, req[own] = 1, hcnt = MAX_HOLD-1, another req bit set: forced rotation; next owner = first set bit in search order excluding current owner; hcnt = 0.
REQ-017 GRANT, req[own] = 0, other req bits set: direct handoff to first set bit in search order excluding current owner, no idle gap; hcnt = 0.
REQ-018 GRANT, req[own] = 0, req == 0: return to IDLE; gnt = 0 next cycle; s1/s0 keep the released owner's index.
REQ-019 SHALL drive {s1,s0} = binary index of owner whenever gnt != 0 (gnt[2] -> s1=1, s0=0).
REQ-020 gnt SHALL never have more than one bit set; ownership changes only on clock edges.
REQ-021 A request deasserted before being granted SHALL be dropped; no request is latched.
REQ-022 All outputs SHALL be driven directly from flops (no combinational path req -> outputs).

Reset
REQ-023 rst_n = 0 at an edge SHALL force state IDLE, gnt = 4'b0000, s1 = 0, s0 = 0, busy = 0, hcnt = 0, last = 3 (requester 0 wins first), overriding any transition in that cycle.
REQ-024 Reset asserted mid-grant SHALL drop the owner at that edge; after rst_n returns to 1, arbitration restarts as in REQ-013 with last = 3.
REQ-025 Outputs before the first reset edge are undefined; the bench SHALL apply rst_n = 0 for at least 2 cycles.

Verification
REQ-026 Reset, then req = 4'b1111 -> cycle after: gnt = 0001, s1s0 = 00, busy = 1.
REQ-027 MAX_HOLD = 8, req = 4'b0101 held constant -> gnt = 0001 for 8 cycles, then 0100 for 8 cycles, then 0001; s1s0 alternates 00/10.
REQ-028 Owner 1 only (req = 0010) held 20 cycles -> gnt = 0010 throughout (saturation, no rotation); then req = 0000 -> gnt = 0000, busy = 0, s1s0 stays 01.
REQ-029 Owner 2 granted, req changes 0100 -> 1001 in one cycle -> next gnt = 1000 (search 3,0,1), no zero-grant cycle, s1s0 = 11.
REQ-030 rst_n pulled low 1 cycle during gnt = 1000 with req = 1111 -> gnt = 0000, s1s0 = 00 at reset edge; after release gnt = 0001.
REQ-031 Every cycle: assert gnt one-hot-or-zero, busy == |gnt, and {s1,s0} matches gnt index when busy; the mux4to1 output equals the selected data input.
